// File: rtl/pll_seq_pkg.sv
// Shared types for the audio PLL lock sequencer: FSM state encoding, counter widths,
// and the state-to-output decode used to register outputs alongside the state.
`timescale 1ns/1ps
package pll_seq_pkg;

    localparam int RETRY_W = 4;
    localparam int LOSS_W  = 8;

    typedef enum logic [2:0] {
        S_RESET     = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RUN       = 3'd3,
        S_FAULT     = 3'd4
    } state_t;

    typedef struct packed {
        logic pll_rst;
        logic codec_rst_n;
        logic ready;
        logic fault;
    } seq_out_t;

    function automatic seq_out_t state_outputs(input state_t s);
        seq_out_t o;
        o.pll_rst     = (s == S_RESET) || (s == S_FAULT);
        o.codec_rst_n = (s == S_RUN);
        o.ready       = (s == S_RUN);
        o.fault       = (s == S_FAULT);
        return o;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer with synchronous active-low clear; 2-cycle latency, no backpressure.
`timescale 1ns/1ps
module sync_2ff (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock/qualify sequencer gating the codec reset; outputs registered with the state,
// lock input seen 2 cycles late via synchronizer. LOCK_LOSS_CNT_EN enables the lock-loss counter.
`timescale 1ns/1ps
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int unsigned RST_PULSE_CYC    = 16,
    parameter int unsigned LOCK_TIMEOUT_CYC = 50000,
    parameter int unsigned LOCK_STABLE_CYC  = 1024,
    parameter int unsigned MAX_RETRY        = 3,
    parameter int unsigned CNT_W            = 16
) (
    input  logic               refclk,
    input  logic               rst_n,
    input  logic               restart,
    input  logic               pll_locked,
    output logic               pll_rst,
    output logic               codec_rst_n,
    output logic               ready,
    output logic               fault,
    output logic [RETRY_W-1:0] retry_cnt,
    output logic [LOSS_W-1:0]  lock_loss_cnt
);

    logic               w_lock_sync;
    state_t             w_fail_state;
    logic [RETRY_W-1:0] w_retry_inc;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    seq_out_t           r_out;
    logic [RETRY_W-1:0] r_retry;

    sync_2ff u_lock_sync (
        .i_clk   (refclk),
        .i_rst_n (rst_n),
        .i_d     (pll_locked),
        .o_q     (w_lock_sync)
    );

    // The last allowed failure lands in S_FAULT; earlier ones re-pulse the PLL.
    assign w_fail_state = (r_retry == RETRY_W'(MAX_RETRY - 1)) ? S_FAULT : S_RESET;
    assign w_retry_inc  = (r_retry == RETRY_W'(MAX_RETRY)) ? r_retry : r_retry + RETRY_W'(1);

    always_ff @(posedge refclk) begin
        if (!rst_n || restart) begin
            r_state <= S_RESET;
            r_cnt   <= '0;
            r_out   <= state_outputs(S_RESET);
            r_retry <= '0;
        end else begin
            case (r_state)
                S_RESET: begin
                    if (r_cnt == CNT_W'(RST_PULSE_CYC - 1)) begin
                        r_state <= S_WAIT_LOCK;
                        r_cnt   <= '0;
                        r_out   <= state_outputs(S_WAIT_LOCK);
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_WAIT_LOCK: begin
                    if (w_lock_sync) begin
                        r_state <= S_STABLE;
                        r_cnt   <= '0;
                        r_out   <= state_outputs(S_STABLE);
                    end else if (r_cnt == CNT_W'(LOCK_TIMEOUT_CYC - 1)) begin
                        r_state <= w_fail_state;
                        r_cnt   <= '0;
                        r_out   <= state_outputs(w_fail_state);
                        r_retry <= w_retry_inc;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_STABLE: begin
                    if (!w_lock_sync) begin
                        r_state <= w_fail_state;
                        r_cnt   <= '0;
                        r_out   <= state_outputs(w_fail_state);
                        r_retry <= w_retry_inc;
                    end else if (r_cnt == CNT_W'(LOCK_STABLE_CYC - 1)) begin
                        r_state <= S_RUN;
                        r_cnt   <= '0;
                        r_out   <= state_outputs(S_RUN);
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_RUN: begin
                    // Losing lock after qualification is not a failed attempt.
                    if (!w_lock_sync) begin
                        r_state <= S_RESET;
                        r_cnt   <= '0;
                        r_out   <= state_outputs(S_RESET);
                        r_retry <= '0;
                    end
                end
                S_FAULT: begin
                    r_state <= S_FAULT;
                end
                default: begin
                    r_state <= S_RESET;
                    r_cnt   <= '0;
                    r_out   <= state_outputs(S_RESET);
                    r_retry <= '0;
                end
            endcase
        end
    end

`ifdef LOCK_LOSS_CNT_EN
    logic              w_loss_evt;
    logic [LOSS_W-1:0] r_loss_cnt;

    assign w_loss_evt = !restart && (r_state == S_RUN) && !w_lock_sync;

    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            r_loss_cnt <= '0;
        end else if (w_loss_evt && (r_loss_cnt != '1)) begin
            r_loss_cnt <= r_loss_cnt + LOSS_W'(1);
        end
    end

    assign lock_loss_cnt = r_loss_cnt;
`else
    assign lock_loss_cnt = '0;
`endif

    assign pll_rst     = r_out.pll_rst;
    assign codec_rst_n = r_out.codec_rst_n;
    assign ready       = r_out.ready;
    assign fault       = r_out.fault;
    assign retry_cnt   = r_retry;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with an attempt-level reference model checked every cycle.
`timescale 1ns/1ps
module tb_pll_lock_sequencer;

    localparam int RST  = 4;
    localparam int TO   = 100;
    localparam int STB  = 8;
    localparam int MAXR = 2;
`ifdef LOCK_LOSS_CNT_EN
    localparam int EXP_LOSS1 = 1;
`else
    localparam int EXP_LOSS1 = 0;
`endif

    logic       refclk = 1'b0;
    logic       rst_n;
    logic       restart;
    logic       pll_locked;
    logic       pll_rst;
    logic       codec_rst_n;
    logic       ready;
    logic       fault;
    logic [3:0] retry_cnt;
    logic [7:0] lock_loss_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 refclk = ~refclk;

    pll_lock_sequencer #(
        .RST_PULSE_CYC    (RST),
        .LOCK_TIMEOUT_CYC (TO),
        .LOCK_STABLE_CYC  (STB),
        .MAX_RETRY        (MAXR),
        .CNT_W            (16)
    ) dut (
        .refclk        (refclk),
        .rst_n         (rst_n),
        .restart       (restart),
        .pll_locked    (pll_locked),
        .pll_rst       (pll_rst),
        .codec_rst_n   (codec_rst_n),
        .ready         (ready),
        .fault         (fault),
        .retry_cnt     (retry_cnt),
        .lock_loss_cnt (lock_loss_cnt)
    );

    // Model: an attempt is a pulse of RST edges followed by a post-pulse edge sequence;
    // it succeeds once the first synced-high edge is followed by STB more high edges.
    int   m_valid = 0;
    int   m_mode  = 0;   // 0 attempt in progress, 1 running, 2 faulted
    int   m_e     = 0;
    int   m_first = 0;
    int   m_retry = 0;
    int   m_loss  = 0;
    logic m_h1    = 1'b0;
    logic m_h2    = 1'b0;

    initial begin : model
        logic        ls;
        logic        ep;
        logic [15:0] exp_vec;
        logic [15:0] act_vec;
        int          k;
        forever begin
            @(negedge refclk);
            if (m_valid != 0) begin
                ep      = (m_mode == 2) || (m_mode == 0 && m_e < RST);
                exp_vec = {ep, m_mode == 1, m_mode == 1, m_mode == 2, 4'(m_retry), 8'(m_loss)};
                act_vec = {pll_rst, codec_rst_n, ready, fault, retry_cnt, lock_loss_cnt};
                n_chk++;
                if (act_vec !== exp_vec) begin
                    n_fail++;
                    $display("FAIL model_cmp t=%0t {rst,crst_n,rdy,flt,retry,loss}: dut=%h model=%h",
                             $time, act_vec, exp_vec);
                end
            end
            if (rst_n !== 1'b1) begin
                m_valid = 1; m_mode = 0; m_e = 0; m_first = 0;
                m_retry = 0; m_loss = 0; m_h1 = 1'b0; m_h2 = 1'b0;
            end else begin
                ls   = m_h2;
                m_h2 = m_h1;
                m_h1 = pll_locked;
                if (restart === 1'b1) begin
                    m_mode = 0; m_e = 0; m_first = 0; m_retry = 0;
                end else if (m_mode == 0) begin
                    m_e++;
                    if (m_e > RST) begin
                        k = m_e - RST;
                        if ((m_first == 0 && !ls && k == TO) || (m_first != 0 && !ls)) begin
                            m_retry++;
                            if (m_retry >= MAXR) m_mode = 2;
                            else begin m_mode = 0; m_e = 0; m_first = 0; end
                        end else if (m_first == 0 && ls) begin
                            m_first = k;
                        end else if (m_first != 0 && k - m_first == STB) begin
                            m_mode = 1;
                        end
                    end
                end else if (m_mode == 1 && !ls) begin
`ifdef LOCK_LOSS_CNT_EN
                    if (m_loss < 255) m_loss++;
`endif
                    m_mode = 0; m_e = 0; m_first = 0; m_retry = 0;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge refclk);
        #2;
    endtask

    task automatic measure_rst(input logic lvl, output int len);
        len = 0;
        while (pll_rst === lvl && len < 300) begin
            len++;
            step(1);
        end
    endtask

    task automatic wait_ready(input logic lvl, input int budget, output int n);
        n = 0;
        while (ready !== lvl && n < budget) begin
            step(1);
            n++;
        end
        if (ready !== lvl) n = -1;
    endtask

    initial begin : stim
        int len;
        int n;
        int rdy_seen;
        rst_n = 1'b0; restart = 1'b0; pll_locked = 1'b0;
        step(3);
        rst_n = 1'b1;

        // 1: power-up sequence
        check("t1_rst_pll_rst", pll_rst, 1);
        check("t1_rst_codec", codec_rst_n, 0);
        check("t1_rst_ready", ready, 0);
        check("t1_rst_retry", retry_cnt, 0);
        measure_rst(1'b1, len);
        check("t1_pulse_len", len, 4);
        step(16);
        pll_locked = 1'b1;
        wait_ready(1'b1, 50, n);
        check("t1_ready_delay", n, 11);
        check("t1_codec_up", codec_rst_n, 1);
        check("t1_retry", retry_cnt, 0);

        // 5: lock loss in S_RUN, then restart on the loss edge
        step(5);
        pll_locked = 1'b0;
        wait_ready(1'b0, 20, n);
        check("t5_loss_delay", n, 3);
        check("t5_codec_down", codec_rst_n, 0);
        check("t5_pll_rst", pll_rst, 1);
        check("t5_loss_cnt", lock_loss_cnt, EXP_LOSS1);
        check("t5_retry", retry_cnt, 0);
        measure_rst(1'b1, len);
        check("t5_pulse_len", len, 4);
        pll_locked = 1'b1;
        wait_ready(1'b1, 50, n);
        check("t5_relock_delay", n, 11);
        step(3);
        pll_locked = 1'b0;
        step(2);
        restart = 1'b1;
        step(1);
        restart = 1'b0;
        check("t5_restart_loss_cnt", lock_loss_cnt, EXP_LOSS1);
        check("t5_restart_ready", ready, 0);
        check("t5_restart_pll_rst", pll_rst, 1);

        // 4: one-cycle glitch while qualifying
        measure_rst(1'b1, len);
        pll_locked = 1'b1;
        step(5);
        pll_locked = 1'b0;
        step(1);
        pll_locked = 1'b1;
        n = 0; rdy_seen = 0;
        while (pll_rst !== 1'b1 && n < 10) begin
            step(1);
            n++;
            if (ready !== 1'b0) rdy_seen++;
        end
        check("t4_fail_delay", n, 2);
        check("t4_retry", retry_cnt, 1);
        measure_rst(1'b1, len);
        check("t4_pulse_len", len, 4);
        check("t4_ready_low", rdy_seen, 0);
        wait_ready(1'b1, 50, n);
        check("t4_reready_delay", n, 9);

        // 6: synchronous reset from S_RUN
        step(2);
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        check("t6_pll_rst", pll_rst, 1);
        check("t6_codec", codec_rst_n, 0);
        check("t6_ready", ready, 0);
        check("t6_fault", fault, 0);
        check("t6_retry", retry_cnt, 0);
        check("t6_loss", lock_loss_cnt, 0);

        // 2: no lock at all -> two timeouts then fault
        pll_locked = 1'b0;
        measure_rst(1'b1, len);
        check("t2_pulse1", len, 4);
        measure_rst(1'b0, len);
        check("t2_timeout1", len, 100);
        check("t2_retry1", retry_cnt, 1);
        measure_rst(1'b1, len);
        check("t2_pulse2", len, 4);
        measure_rst(1'b0, len);
        check("t2_timeout2", len, 100);
        check("t2_fault", fault, 1);
        check("t2_retry2", retry_cnt, 2);
        step(20);
        check("t2_fault_hold", fault, 1);
        check("t2_pll_rst_hold", pll_rst, 1);

        // 3: restart out of S_FAULT
        restart = 1'b1;
        step(1);
        restart = 1'b0;
        check("t3_fault_clr", fault, 0);
        check("t3_retry_clr", retry_cnt, 0);
        pll_locked = 1'b1;
        wait_ready(1'b1, 50, n);
        check("t3_ready_delay", n, 13);
        check("t3_fault_low", fault, 0);

        step(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
